// File: rtl/controle_balanca_if.sv
// Bundle between the load-cell sample source / display driver and the scale price sequencer.
interface controle_balanca_if #(parameter int LARG = 32);
    logic            amostra_ok;
    logic [LARG-1:0] peso_bruto;
    logic [LARG-1:0] preco_kg;
    logic            botao_tara;
    logic [LARG-1:0] saida_peso;
    logic [LARG-1:0] saida_preco;
    logic            valido;
    logic            ocupado;
    logic            estouro;

    modport master (
        output amostra_ok, peso_bruto, preco_kg, botao_tara,
        input  saida_peso, saida_preco, valido, ocupado, estouro
    );

    modport slave (
        input  amostra_ok, peso_bruto, preco_kg, botao_tara,
        output saida_peso, saida_preco, valido, ocupado, estouro
    );
endinterface

// File: rtl/controle_balanca.sv
// Scale price sequencer: tare, stability detection, then price = net*price/ESCALA computed
// with a shift-add multiplier followed by a restoring divider.
//
// state   | meaning
// OCIOSO  | after reset, waiting for the first sample
// ESTAVEL | counting consecutive samples within TOL of the previous one
// MULT    | LARG shift-add steps, one multiplier bit per cycle
// DIV     | 2*LARG restoring-division steps, one quotient bit per cycle
// PRONTO  | result shown, left when a sample moves beyond TOL
module controle_balanca #(
    parameter int LARG      = 32,
    parameter int TOL       = 2,
    parameter int N_ESTAVEL = 4,
    parameter int ESCALA    = 1000
) (
    input logic               clk,
    input logic               rst,
    controle_balanca_if.slave bus
);
    localparam int CW = $clog2(N_ESTAVEL + 1);
    localparam int BW = $clog2(2 * LARG);

    typedef enum logic [2:0] {OCIOSO, ESTAVEL, MULT, DIV, PRONTO} estado_t;

    estado_t           estado, prox;
    logic [LARG-1:0]   tara, ref_peso, liq_lat, mplier, resto;
    logic [CW-1:0]     cnt, cnt_prox;
    logic [BW-1:0]     cnt_bits;
    logic [2*LARG-1:0] mcand, prod, quoc;

    logic [LARG-1:0]   dif, liq;
    logic              dentro_tol, tara_ok, amostra_valida, atinge_n;
    logic [LARG:0]     trial, sub;
    logic              q_bit, estouro_prox;
    logic [2*LARG-1:0] quoc_prox;

    always_comb begin
        dif            = (bus.peso_bruto >= ref_peso) ? bus.peso_bruto - ref_peso
                                                      : ref_peso - bus.peso_bruto;
        dentro_tol     = (dif <= LARG'(TOL));
        liq            = (bus.peso_bruto >= tara) ? bus.peso_bruto - tara : '0;
        tara_ok        = bus.botao_tara && (estado == OCIOSO || estado == ESTAVEL || estado == PRONTO);
        amostra_valida = bus.amostra_ok && !tara_ok;
        // cnt==0 means no reference yet (fresh after tare), so the sample starts a new run
        cnt_prox       = (cnt == '0 || !dentro_tol) ? CW'(1) : cnt + CW'(1);
        atinge_n       = (cnt_prox == CW'(N_ESTAVEL));
        trial          = {resto, prod[2*LARG-1]};
        q_bit          = (trial >= (LARG+1)'(ESCALA));
        sub            = trial - (LARG+1)'(ESCALA);
        quoc_prox      = {quoc[2*LARG-2:0], q_bit};
        estouro_prox   = |quoc_prox[2*LARG-1:LARG];
    end

    always_ff @(posedge clk) begin
        if (rst) estado <= OCIOSO;
        else     estado <= prox;
    end

    always_comb begin
        prox = estado;
        case (estado)
            OCIOSO:  if (tara_ok || amostra_valida) prox = ESTAVEL;
            ESTAVEL: if (amostra_valida && atinge_n) prox = MULT;
            MULT:    if (cnt_bits == '0) prox = DIV;
            DIV:     if (cnt_bits == '0) prox = PRONTO;
            PRONTO:  if (tara_ok || (amostra_valida && !dentro_tol)) prox = ESTAVEL;
            default: prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tara            <= '0;
            ref_peso        <= '0;
            liq_lat         <= '0;
            cnt             <= '0;
            cnt_bits        <= '0;
            mplier          <= '0;
            mcand           <= '0;
            prod            <= '0;
            resto           <= '0;
            quoc            <= '0;
            bus.saida_peso  <= '0;
            bus.saida_preco <= '0;
            bus.valido      <= 1'b0;
            bus.ocupado     <= 1'b0;
            bus.estouro     <= 1'b0;
        end else begin
            bus.ocupado <= (prox == MULT) || (prox == DIV);
            case (estado)
                OCIOSO, ESTAVEL, PRONTO: begin
                    if (tara_ok) begin
                        tara       <= bus.peso_bruto;
                        cnt        <= '0;
                        bus.valido <= 1'b0;
                    end else if (amostra_valida) begin
                        if (estado == OCIOSO) begin
                            ref_peso <= bus.peso_bruto;
                            cnt      <= CW'(1);
                        end else if (estado == ESTAVEL) begin
                            ref_peso <= bus.peso_bruto;
                            cnt      <= cnt_prox;
                            if (atinge_n) begin
                                liq_lat  <= liq;
                                mplier   <= bus.preco_kg;
                                mcand    <= {{LARG{1'b0}}, liq};
                                prod     <= '0;
                                cnt      <= '0;
                                cnt_bits <= BW'(LARG - 1);
                            end
                        end else if (!dentro_tol) begin
                            ref_peso   <= bus.peso_bruto;
                            cnt        <= CW'(1);
                            bus.valido <= 1'b0;
                        end
                    end
                end
                MULT: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt_bits == '0) begin
                        cnt_bits <= BW'(2 * LARG - 1);
                        resto    <= '0;
                        quoc     <= '0;
                    end else begin
                        cnt_bits <= cnt_bits - BW'(1);
                    end
                end
                DIV: begin
                    resto    <= q_bit ? sub[LARG-1:0] : trial[LARG-1:0];
                    prod     <= prod << 1;
                    quoc     <= quoc_prox;
                    cnt_bits <= cnt_bits - BW'(1);
                    if (cnt_bits == '0) begin
                        bus.saida_peso  <= liq_lat;
                        bus.saida_preco <= estouro_prox ? '1 : quoc_prox[LARG-1:0];
                        bus.estouro     <= estouro_prox;
                        bus.valido      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
